// File: rtl/game_pkg.sv
// game_pkg: shared states, results, line masks and square decoding for the referee
package game_pkg;
  typedef enum logic [2:0] {WAIT_HUMAN, H_CHECK, ISSUE, C_CHECK, DONE} state_t;
  typedef enum logic [2:0] {NONE, HUMAN_WIN, COMP_WIN, DRAW, FAULT} result_t;
  localparam logic [3:0] NO_MOVE = 4'hF;
  localparam logic [8:0] FULL = 9'h1FF;
  localparam logic [8:0] LINES [8] = '{9'h007, 9'h038, 9'h1C0, 9'h049, 9'h092, 9'h124, 9'h111, 9'h054};
  function automatic logic [8:0] square_to_onehot(input logic [3:0] s);
    return (s >= 4'd1 && s <= 4'd9) ? 9'd1 << (s - 4'd1) : 9'd0;
  endfunction
endpackage

// File: rtl/game_referee_line_detect.sv
// line_detect: flags a board that holds any complete row, column or diagonal
module line_detect
  import game_pkg::*;
(
  input  logic [8:0] board,
  output logic       line
);
  always_comb begin
    line = 1'b0;
    for (int i = 0; i < 8; i++) line = line | ((board & LINES[i]) == LINES[i]);
  end
endmodule

// File: rtl/game_referee.sv
// game_referee: turn sequencer between human move entry and the computer strategy FSM
module game_referee
  import game_pkg::*;
#(
  parameter int RESP_LATENCY = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] move_in,
  input  logic       move_valid,
  output logic       move_ready,
  output logic       illegal,
  output logic [3:0] hMove,
  input  logic [3:0] cMove,
  input  logic       win,
  output logic [8:0] human_board,
  output logic [8:0] comp_board,
  output logic [3:0] move_count,
  output logic       game_over,
  output result_t    result
);
  state_t state, state_n;
  result_t result_n;
  logic [8:0] hb_n, cb_n, occ, h_oh, c_oh;
  logic [3:0] move_reg, move_reg_n, c_reg, c_reg_n;
  logic [2:0] cnt, cnt_n;
  logic w_reg, w_reg_n, illegal_n, h_line, c_line;
  assign occ = human_board | comp_board;
  assign h_oh = square_to_onehot(move_in);
  assign c_oh = square_to_onehot(c_reg);
  assign move_ready = state == WAIT_HUMAN;
  assign game_over = state == DONE;
  assign hMove = state == ISSUE ? move_reg : NO_MOVE;
  assign move_count = 4'($countones(occ));
  // the comp detector sees the board as it would be after the pending reply
  line_detect u_hline (.board(human_board), .line(h_line));
  line_detect u_cline (.board(comp_board | c_oh), .line(c_line));
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= WAIT_HUMAN;
      human_board <= '0;
      comp_board <= '0;
      move_reg <= '0;
      c_reg <= '0;
      w_reg <= 1'b0;
      cnt <= '0;
      illegal <= 1'b0;
      result <= NONE;
    end else begin
      state <= state_n;
      human_board <= hb_n;
      comp_board <= cb_n;
      move_reg <= move_reg_n;
      c_reg <= c_reg_n;
      w_reg <= w_reg_n;
      cnt <= cnt_n;
      illegal <= illegal_n;
      result <= result_n;
    end
  end
  always_comb begin
    state_n = state;
    hb_n = human_board;
    cb_n = comp_board;
    move_reg_n = move_reg;
    c_reg_n = c_reg;
    w_reg_n = w_reg;
    cnt_n = cnt;
    illegal_n = 1'b0;
    result_n = result;
    case (state)
      WAIT_HUMAN: begin
        cnt_n = '0;
        if (move_valid) begin
          if (h_oh == 9'd0 || (h_oh & occ) != 9'd0) illegal_n = 1'b1;
          else begin
            hb_n = human_board | h_oh;
            move_reg_n = move_in;
            state_n = H_CHECK;
          end
        end
      end
      H_CHECK: begin
        state_n = (h_line || occ == FULL) ? DONE : ISSUE;
        result_n = h_line ? HUMAN_WIN : occ == FULL ? DRAW : result;
      end
      ISSUE: begin
        if (cnt == 3'(RESP_LATENCY - 1)) begin
          c_reg_n = cMove;
          w_reg_n = win;
          state_n = C_CHECK;
        end else cnt_n = cnt + 3'd1;
      end
      C_CHECK: begin
        if (c_oh == 9'd0 || (c_oh & occ) != 9'd0) begin
          state_n = DONE;
          result_n = FAULT;
        end else begin
          cb_n = comp_board | c_oh;
          state_n = (w_reg || c_line || (occ | c_oh) == FULL) ? DONE : WAIT_HUMAN;
          result_n = (w_reg || c_line) ? COMP_WIN : (occ | c_oh) == FULL ? DRAW : result;
        end
      end
      DONE: state_n = DONE;
      default: state_n = WAIT_HUMAN;
    endcase
  end
endmodule

// File: tb/tb_game_referee.sv
// tb_game_referee: scoreboard bench driving scripted games against a stub strategy FSM
module tb_game_referee;
  import game_pkg::*;
  localparam int LAT = 3;
  localparam int T [8][3] = '{'{1,2,3}, '{4,5,6}, '{7,8,9}, '{1,4,7}, '{2,5,8}, '{3,6,9}, '{1,5,9}, '{3,5,7}};
  typedef struct packed {
    logic       ill;
    logic [8:0] hb;
    logic [8:0] cb;
    logic [3:0] cnt;
    logic [2:0] res;
    logic       over;
    logic [3:0] hcyc;
    logic [5:0] rdy;
  } exp_t;
  logic clock = 1'b0, reset = 1'b1, move_valid = 1'b0, win = 1'b0;
  logic [3:0] move_in = 4'd0, cMove = 4'd0;
  logic move_ready, illegal, game_over;
  logic [3:0] hMove, move_count;
  logic [8:0] human_board, comp_board;
  result_t result;
  exp_t sb[$];
  int n_cmp = 0, n_bad = 0;
  logic [8:0] hb_m, cb_m;
  result_t res_m;
  always #5 clock = ~clock;
  game_referee #(.RESP_LATENCY(LAT)) dut (
    .clock(clock), .reset(reset), .move_in(move_in), .move_valid(move_valid),
    .move_ready(move_ready), .illegal(illegal), .hMove(hMove), .cMove(cMove), .win(win),
    .human_board(human_board), .comp_board(comp_board), .move_count(move_count),
    .game_over(game_over), .result(result)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [8:0] oh(input int s);
    return (s >= 1 && s <= 9) ? 9'd1 << (s - 1) : 9'd0;
  endfunction
  function automatic logic has_line(input logic [8:0] b);
    logic r = 1'b0;
    for (int i = 0; i < 8; i++) if (b[T[i][0]-1] && b[T[i][1]-1] && b[T[i][2]-1]) r = 1'b1;
    return r;
  endfunction
  task automatic chk_reset(input string tag);
    check({tag, "_hb"}, human_board, 0);
    check({tag, "_cb"}, comp_board, 0);
    check({tag, "_cnt"}, move_count, 0);
    check({tag, "_hmove"}, hMove, 4'hF);
    check({tag, "_ill"}, illegal, 0);
    check({tag, "_over"}, game_over, 0);
    check({tag, "_res"}, result, NONE);
    check({tag, "_rdy"}, move_ready, 1);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    move_valid = 1'b0;
    repeat (2) @(negedge clock);
    chk_reset("rst");
    reset = 1'b0;
    hb_m = '0;
    cb_m = '0;
    res_m = NONE;
  endtask
  task automatic play(input int mv, input int cm, input logic w);
    exp_t e, g;
    logic [8:0] m, c;
    logic [3:0] hv;
    logic ill_seen;
    int k, hc;
    e = '0;
    m = oh(mv);
    if (m == 0 || (m & (hb_m | cb_m)) != 0) begin
      e.ill = 1'b1;
      e.rdy = 1;
    end else begin
      hb_m |= m;
      if (has_line(hb_m)) begin res_m = HUMAN_WIN; e.rdy = 2; end
      else if ((hb_m | cb_m) == 9'h1FF) begin res_m = DRAW; e.rdy = 2; end
      else begin
        e.hcyc = 4'(LAT);
        e.rdy = 6'(3 + LAT);
        c = oh(cm);
        if (c == 0 || (c & (hb_m | cb_m)) != 0) res_m = FAULT;
        else begin
          cb_m |= c;
          if (w || has_line(cb_m)) res_m = COMP_WIN;
          else if ((hb_m | cb_m) == 9'h1FF) res_m = DRAW;
        end
      end
    end
    e.hb = hb_m;
    e.cb = cb_m;
    e.cnt = 4'($countones(hb_m | cb_m));
    e.res = res_m;
    e.over = res_m != NONE;
    sb.push_back(e);
    cMove = 4'(cm);
    win = w;
    k = 0;
    while (!move_ready && k < 20) begin @(negedge clock); k++; end
    if (!move_ready) check("ready_timeout", 0, 1);
    move_in = 4'(mv);
    move_valid = 1'b1;
    @(negedge clock);
    move_valid = 1'b0;
    move_in = 4'd0;
    k = 1;
    hc = 0;
    hv = NO_MOVE;
    ill_seen = illegal;
    while (!(move_ready || game_over) && k < 40) begin
      @(negedge clock);
      k++;
      if (hMove != NO_MOVE) begin hc++; hv = hMove; end
    end
    g = sb.pop_front();
    check("illegal", ill_seen, g.ill);
    check("human_board", human_board, g.hb);
    check("comp_board", comp_board, g.cb);
    check("move_count", move_count, g.cnt);
    check("result", result, g.res);
    check("game_over", game_over, g.over);
    check("hmove_cycles", hc, g.hcyc);
    check("turn_cycles", k, g.rdy);
    if (g.hcyc != 0) check("hmove_value", hv, mv);
    if (g.ill) begin
      @(negedge clock);
      check("illegal_pulse", illegal, 0);
    end
  endtask
  initial begin
    do_reset();
    play(6, 9, 0);
    play(6, 0, 0);
    play(9, 0, 0);
    play(0, 0, 0);
    play(12, 0, 0);
    do_reset();
    play(1, 4, 0);
    play(2, 5, 0);
    play(3, 0, 0);
    move_in = 4'd7;
    move_valid = 1'b1;
    repeat (2) @(negedge clock);
    move_valid = 1'b0;
    check("done_hb", human_board, 9'h007);
    check("done_ill", illegal, 0);
    check("done_over", game_over, 1);
    check("done_hmove", hMove, 4'hF);
    check("done_rdy", move_ready, 0);
    do_reset();
    play(7, 2, 1);
    do_reset();
    play(7, 7, 0);
    do_reset();
    play(1, 2, 0);
    play(3, 5, 0);
    play(4, 7, 0);
    play(8, 6, 0);
    play(9, 1, 0);
    do_reset();
    play(1, 5, 0);
    play(2, 3, 0);
    play(9, 7, 0);
    do_reset();
    play(5, 1, 0);
    move_in = 4'd9;
    move_valid = 1'b1;
    @(negedge clock);
    move_valid = 1'b0;
    for (int i = 0; i < 10 && hMove == NO_MOVE; i++) @(negedge clock);
    check("issue_reached", hMove, 9);
    reset = 1'b1;
    #1;
    chk_reset("mid_rst");
    @(negedge clock);
    reset = 1'b0;
    hb_m = '0;
    cb_m = '0;
    res_m = NONE;
    play(2, 1, 0);
    play(9, 5, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/game_referee.md
Name: game_referee

Overview:
- Turn sequencer between the human move entry and the computer strategy FSM (clock/reset/hMove/cMove/win interface).
- Accepts one human move per turn with a valid/ready handshake and rejects illegal squares.
- Presents each accepted move to the strategy FSM, collects the computer's reply, and keeps both boards.
- Declares the game result: human win, computer win, draw, or computer fault.

Parameters:
RESP_LATENCY, 1, cycles hMove is held to the strategy FSM before cMove/win are sampled (legal range 1..7).

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
move_in  input  4  human square, legal values 1..9.
move_valid  input  1  move_in is valid this cycle.
move_ready  output  1  referee can accept a human move.
illegal  output  1  one-cycle pulse: the offered move was rejected.
hMove  output  4  move presented to the strategy FSM; 4'hF when idle.
cMove  input  4  computer reply from the strategy FSM.
win  input  1  strategy FSM reports a computer win.
human_board  output  9  bit k-1 set means square k is held by the human.
comp_board  output  9  bit k-1 set means square k is held by the computer.
move_count  output  4  number of occupied squares, 0..9.
game_over  output  1  the game has ended.
result  output  3  result_t: NONE, HUMAN_WIN, COMP_WIN, DRAW, FAULT.

Behaviour:
- Reset values (async, any state): state=WAIT_HUMAN, both boards 0, move_count 0, hMove 4'hF, illegal 0, game_over 0, result NONE, move_ready 1.
- WAIT_HUMAN:
  - move_ready=1.
  - Accept on the edge where move_valid&&move_ready.
  - Reject if move_in is 0 or 10..15, or if the square is set in either board: illegal=1 next cycle for exactly 1 cycle; boards unchanged; stay in WAIT_HUMAN.
  - Legal: set the human bit, latch move_reg, go to H_CHECK.
- H_CHECK (1 cycle, move_ready=0):
  - Human line present → DONE, result HUMAN_WIN.
  - Else board full (9 squares) → DONE, result DRAW.
  - Else → ISSUE.
- ISSUE:
  - hMove=move_reg for exactly RESP_LATENCY cycles, counted by a wait counter.
  - On the last cycle's edge, register cMove and win into c_reg and w_reg, then go to C_CHECK.
- C_CHECK (1 cycle), priority order:
  - c_reg is 0, 10..15, or already occupied → DONE, result FAULT; boards unchanged.
  - Else set the comp bit; then w_reg or a comp line on the updated board → COMP_WIN.
  - Else updated board full → DRAW.
  - Else → WAIT_HUMAN.
- DONE:
  - game_over=1, move_ready=0, hMove=4'hF.
  - Boards and result held until reset; move_valid is ignored.
- hMove=4'hF in every state except ISSUE.
- Turn timing: move_ready returns 3+RESP_LATENCY cycles after the acceptance edge.
- move_count always equals popcount(human_board|comp_board).
- Boards never overlap; a square, once set, clears only on reset.
- Lines: rows 123/456/789, columns 147/258/369, diagonals 159/357.
- Reset asserted mid-turn, including during ISSUE, aborts the turn immediately. No partial board update survives.

Decomposition:
- game_pkg holds:
  - state_t: WAIT_HUMAN, H_CHECK, ISSUE, C_CHECK, DONE.
  - result_t.
  - NO_MOVE=4'hF.
  - The 8 line masks as a 9-bit constant array.
  - A square_to_onehot function (returns 0 for illegal squares).
- Sub-module line_detect: combinational, input 9-bit board, output 1-bit any-line. Two instances: human board, prospective comp board.

Test Plan:
1. Reset, move 6 offered at cycle 0, stub returns cMove=9, win=0 → hMove=6 for exactly 1 cycle; human_board=9'h020, comp_board=9'h100, move_count=2; move_ready high again 4 cycles after acceptance.
2. After scenario 1, offer 6, then 9, then 0, then 12 → illegal pulses once for each; boards and move_count unchanged; hMove stays 4'hF.
3. Human 1,2,3 against stub replies 4,5 → after the third acceptance: result=HUMAN_WIN, game_over=1; hMove never shows 3; move_count=5.
4. Human 7 with stub win=1, cMove=2 → result=COMP_WIN, comp_board=9'h002. Separately, a stub reply of cMove=7 (occupied) → result=FAULT, comp_board unchanged.
5. Script H1 C2 H3 C5 H4 C7 H8 C6 H9 → result=DRAW with move_count=9; the FSM never sees a fifth hMove after 9.
6. Assert reset during ISSUE (RESP_LATENCY=3 build) → all outputs return to reset values on the same cycle; a new game proceeds normally after reset is released.
